// File: rtl/imm_decode_stage.sv
// Immediate generation stage: decodes RISC-V immediates by format and
// queues them with a sideband tag behind a small valid/ready FIFO.
package isa_shared;
    localparam logic [2:0] IMM_3120 = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_CSR  = 3'd5;
endpackage

module imm_decode_stage
    import isa_shared::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    input  logic [2:0]            imm_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $fatal(1, "imm_decode_stage: DATA_WIDTH must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "imm_decode_stage: DEPTH must be a power of two >= 2");
    end

    logic        sgn;
    logic [63:0] imm_wide;
    logic        err_d;

    assign sgn = instruction[31];

    // Built at 64 bits and truncated, so one decoder serves both widths.
    always_comb begin
        imm_wide = '0;
        err_d    = 1'b0;
        unique case (imm_op)
            IMM_3120: imm_wide = {{52{sgn}}, instruction[31:20]};
            IMM_S:    imm_wide = {{52{sgn}}, instruction[31:25],
                                  instruction[11:7]};
            IMM_B:    imm_wide = {{51{sgn}}, instruction[31],
                                  instruction[7], instruction[30:25],
                                  instruction[11:8], 1'b0};
            IMM_U:    imm_wide = {{32{sgn}}, instruction[31:12], 12'b0};
            IMM_J:    imm_wide = {{43{sgn}}, instruction[31],
                                  instruction[19:12], instruction[20],
                                  instruction[30:21], 1'b0};
            IMM_CSR:  imm_wide = {59'b0, instruction[19:15]};
            default:  err_d    = 1'b1;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{instruction[6:0], imm_wide};

    logic [DATA_WIDTH-1:0] mem_imm [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag [DEPTH];
    logic [DEPTH-1:0]      mem_err;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= err_d ? '0 : imm_wide[DATA_WIDTH-1:0];
            mem_tag[wr_ptr] <= in_tag;
            mem_err[wr_ptr] <= err_d;
        end
    end

    assign out_valid = !empty;
    assign out_imm   = empty ? '0 : mem_imm[rd_ptr];
    assign out_tag   = empty ? '0 : mem_tag[rd_ptr];
    assign out_err   = empty ? 1'b0 : mem_err[rd_ptr];
endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: 32- and 64-bit instances on shared stimulus,
// checked against an arithmetic immediate model and a queue scoreboard.
module tb_imm_decode_stage;
    import isa_shared::*;

    localparam int DEPTH = 2;
    localparam longint P31 = 64'sh80000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = '0;
    logic [2:0]  imm_op = '0;
    logic [7:0]  in_tag = '0;

    logic        rdy32, val32, err32;
    logic        rdy64, val64, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag32, tag64;

    always #5 clk = ~clk;

    imm_decode_stage #(.DATA_WIDTH(32), .TAG_WIDTH(8), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .instruction(instruction), .imm_op(imm_op), .in_tag(in_tag),
        .out_valid(val32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_err(err32)
    );

    imm_decode_stage #(.DATA_WIDTH(64), .TAG_WIDTH(8), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .instruction(instruction), .imm_op(imm_op), .in_tag(in_tag),
        .out_valid(val64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_err(err64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } ent_t;

    ent_t q[$];
    int tests = 0;
    int fails = 0;

    // Immediate value as a signed integer, assembled field by field.
    function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] op,
                                            output logic err);
        longint s;
        longint v;
        s = i[31] ? 64'sd1 : 64'sd0;
        v = 0;
        err = 1'b0;
        case (op)
            IMM_3120: v = -2048 * s + longint'(i[30:20]);
            IMM_S:    v = -2048 * s + longint'(i[30:25]) * 32
                          + longint'(i[11:7]);
            IMM_B:    v = -4096 * s + longint'(i[7]) * 2048
                          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            IMM_U:    v = -P31 * s + longint'(i[30:12]) * 4096;
            IMM_J:    v = -1048576 * s + longint'(i[19:12]) * 4096
                          + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            IMM_CSR:  v = longint'(i[19:15]);
            default:  err = 1'b1;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        e.imm = '0;
        e.tag = '0;
        e.err = 1'b0;
        if (q.size() > 0) e = q[0];
        chk("in_ready32", rdy32, q.size() < DEPTH);
        chk("in_ready64", rdy64, q.size() < DEPTH);
        chk("out_valid32", val32, q.size() > 0);
        chk("out_valid64", val64, q.size() > 0);
        chk("out_imm32", imm32, e.imm[31:0]);
        chk("out_imm64", imm64, e.imm);
        chk("out_tag32", tag32, e.tag);
        chk("out_tag64", tag64, e.tag);
        chk("out_err32", err32, e.err);
        chk("out_err64", err64, e.err);
    endtask

    // One clock: predict handshakes from pre-edge state, then check.
    task automatic cycle();
        bit   acc;
        bit   pp;
        ent_t e;
        logic err;
        logic [63:0] v;
        acc = in_valid && (q.size() < DEPTH);
        pp  = out_ready && (q.size() > 0);
        v = ref_imm(instruction, imm_op, err);
        e.imm = err ? 64'd0 : v;
        e.tag = in_tag;
        e.err = err;
        @(posedge clk);
        #1;
        if (pp) q.delete(0);
        if (acc) q.push_back(e);
        check_outputs();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8 && q.size() > 0; k++) cycle();
        chk("drain empty", val32, 1'b0);
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [2:0] op,
                            input logic [7:0] tag, input logic [31:0] e32,
                            input logic [63:0] e64);
        instruction = ins;
        imm_op = op;
        in_tag = tag;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("fmt imm32", imm32, e32);
        chk("fmt imm64", imm64, e64);
        chk("fmt tag", tag32, tag);
        chk("fmt valid", val32, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got[$];

        #1 rst_n = 1'b0;
        #2;
        chk("rst in_ready32", rdy32, 1'b0);
        chk("rst in_ready64", rdy64, 1'b0);
        chk("rst out_valid32", val32, 1'b0);
        chk("rst out_imm64", imm64, 64'd0);
        chk("rst out_tag32", tag32, 8'd0);
        chk("rst out_err32", err32, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        push_one(32'hFFF00093, IMM_3120, 8'h11, 32'hFFFFFFFF,
                 64'hFFFFFFFFFFFFFFFF);
        push_one(32'hFE512E23, IMM_S, 8'h12, 32'hFFFFFFFC,
                 64'hFFFFFFFFFFFFFFFC);
        push_one(32'hFFDFF06F, IMM_J, 8'h13, 32'hFFFFFFFC,
                 64'hFFFFFFFFFFFFFFFC);
        push_one(32'h123450B7, IMM_U, 8'h14, 32'h12345000,
                 64'h0000000012345000);
        push_one(32'h800000B7, IMM_U, 8'h15, 32'h80000000,
                 64'hFFFFFFFF80000000);
        push_one(32'h0007D073, IMM_CSR, 8'h16, 32'h0000000F,
                 64'h000000000000000F);
        drain();

        out_ready = 1'b0;
        in_valid = 1'b1;
        instruction = 32'h00100093;
        imm_op = IMM_3120;
        in_tag = 8'd1;
        cycle();
        in_tag = 8'd2;
        cycle();
        chk("bp in_ready full", rdy32, 1'b0);
        in_tag = 8'd3;
        cycle();
        chk("bp head tag", tag32, 8'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) in_valid = 1'b0;
            if (val32) got.push_back(int'(tag32));
            cycle();
        end
        chk("bp delivered", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk("bp order", 64'(got[k]), 64'(k + 1));

        drain();
        out_ready = 1'b0;
        in_valid = 1'b1;
        instruction = 32'hDEADBEEF;
        imm_op = 3'b111;
        in_tag = 8'hA5;
        cycle();
        chk("rsv err", err32, 1'b1);
        chk("rsv imm32", imm32, 32'd0);
        chk("rsv imm64", imm64, 64'd0);
        chk("rsv tag", tag32, 8'hA5);
        imm_op = IMM_U;
        in_tag = 8'h5A;
        out_ready = 1'b1;
        cycle();
        chk("rsv next err", err32, 1'b0);
        chk("rsv next tag", tag32, 8'h5A);

        for (int n = 0; n < 1000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            instruction = $urandom;
            imm_op = 3'($urandom_range(0, 7));
            in_tag = 8'($urandom);
            cycle();
        end

        drain();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instruction = $urandom;
            imm_op = IMM_S;
            in_tag = 8'(k + 8'h40);
            cycle();
        end
        chk("mid full in_ready", rdy32, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst out_valid32", val32, 1'b0);
        chk("mid rst out_valid64", val64, 1'b0);
        chk("mid rst out_imm32", imm32, 32'd0);
        chk("mid rst out_imm64", imm64, 64'd0);
        chk("mid rst in_ready32", rdy32, 1'b0);
        chk("mid rst in_ready64", rdy64, 1'b0);
        q.delete();
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        chk("post rst in_ready", rdy32, 1'b1);
        in_valid = 1'b1;
        instruction = 32'h00500093;
        imm_op = IMM_3120;
        in_tag = 8'h3C;
        cycle();
        in_valid = 1'b0;
        chk("post rst tag", tag32, 8'h3C);
        chk("post rst imm", imm32, 32'd5);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised RISC-V immediate-generation stage with valid/ready handshakes on both sides and an internal output FIFO. It sits between fetch/decode and the execute stage. Each accepted instruction is turned into a sign-extended immediate of width DATA_WIDTH, chosen by imm_op. An optional tag is carried alongside, and unsupported formats are flagged. It generalises the purely combinational sign extender to all immediate formats, 32/64-bit datapaths and backpressure.

## Interface
- DATA_WIDTH, 32, output immediate width; legal values 32 or 64.
- TAG_WIDTH, 8, width of the sideband tag carried with each instruction (PC index, rd, etc.); minimum 1.
- DEPTH, 2, output FIFO entries; power of two, minimum 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction presented.
- in_ready  output  1  stage can accept; equals !full, and is forced 0 while rst_n is low.
- instruction  input  32  raw instruction word.
- imm_op  input  3  format select, using the isa_shared encodings IMM_3120, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR; every other code is reserved.
- in_tag  input  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_imm  output  DATA_WIDTH  immediate at the FIFO head.
- out_tag  output  TAG_WIDTH  tag at the FIFO head.
- out_err  output  1  head entry had a reserved imm_op.

## Operation
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- Immediate formats, with i = instruction and W = DATA_WIDTH:
  - IMM_3120: sext(i[31:20]).
  - IMM_S: sext({i[31:25], i[11:7]}).
  - IMM_B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - IMM_U: sext({i[31:12], 12'b0}), sign bit i[31]; upper bits fill for W=64.
  - IMM_J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - IMM_CSR: zero-extend i[19:15].
- Reserved imm_op:
  - Entry is still pushed, with imm = 0 and err = 1.
  - Tag is preserved and no instruction is dropped.
- Immediate computation is combinational on the input side. Result, tag and err are written into the FIFO together.
- FIFO: read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter of log2(DEPTH)+1 bits.
- out_imm, out_tag and out_err are driven from the head entry. When the FIFO is empty they hold 0.
- Push and pop in the same cycle:
  - Allowed when not empty and not full; occupancy is unchanged.
  - When full, in_ready = 0, so no push can occur; a pop that cycle makes in_ready = 1 in the next cycle (no same-cycle bypass of full).
  - When empty, no pop occurs; the push makes the entry visible in the next cycle (no flow-through).
- out_valid = (count != 0), registered-state derived.
- A parameter check is issued at elaboration: DATA_WIDTH not in {32, 64} or DEPTH < 2 fails with $fatal.

## Timing
- Latency: push at edge N gives out_valid = 1 with that entry's data after edge N, i.e. visible in cycle N+1.
- Throughput: 1 instruction per cycle sustained while out_ready = 1.
- The output holds stable (imm, tag, err, valid) while out_valid && !out_ready.
- in_ready is combinational from occupancy only; it has no combinational path from in_valid or out_ready.
- Reset, asserted asynchronously at any time (including mid-stream with a full FIFO):
  - Pointers and count go to 0.
  - out_valid = 0, out_imm = 0, out_tag = 0, out_err = 0, in_ready = 0.
  - All in-flight entries are discarded.
- Reset release: in_ready = 1 from the first cycle after rst_n rises, as the FIFO is empty.

## Test plan
- **Format check (DATA_WIDTH=32):**
  - 32'hFFF00093 / IMM_3120 -> out_imm 32'hFFFFFFFF.
  - 32'hFE512E23 / IMM_S -> 32'hFFFFFFFC.
  - 32'hFFDFF06F / IMM_J -> 32'hFFFFFFFC.
  - 32'h123450B7 / IMM_U -> 32'h12345000.
  - Each arrives one cycle after its push, with the matching tag.
- **64-bit:** DATA_WIDTH=64, 32'h800000B7 / IMM_U -> 64'hFFFFFFFF80000000; 32'h0007D073 / IMM_CSR -> 64'h000000000000000F.
- **Backpressure, DEPTH=2:**
  - Hold out_ready = 0 and push tags 1, 2 -> in_ready = 0 after the second push; a third offered instruction is not accepted.
  - Raise out_ready -> tags 1, 2, 3 are delivered in order with no loss or duplication.
- **Streaming:** 1000 random instructions/formats/tags with random out_ready -> every output matches the reference model in order; pointers wrap cleanly.
- **Reserved imm_op (3'b111), tag 8'hA5:** -> entry with out_imm 0, out_err 1, out_tag 8'hA5; the next legal entry has out_err 0.
- **Reset mid-operation:** fill the FIFO, then pulse rst_n low between edges -> out_valid, out_imm and in_ready drop to 0 immediately; after release in_ready = 1 and no stale entries appear.
